// File: rtl/t08_wb_requester.sv
// Wishbone-classic single-transfer requester: turns the handler's level read/write
// request into one bus cycle, returns read data and a busy/done/err handshake.
module t08_wb_requester #(
    parameter int unsigned  TIMEOUT  = 255,
    parameter logic [31:0]  ERR_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        read_req,
    input  logic        write_req,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  sel,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [9:0] LP_LAST = 10'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [9:0]  r_cnt;
    logic        r_err;
    logic        r_we;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [3:0]  r_sel;
    logic [31:0] r_rdata;
    logic        w_req;
    logic        w_timeout;

    assign w_req     = read_req | write_req;
    assign w_timeout = (r_cnt == LP_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req) w_next = S_REQ;
            S_REQ:   if (wb_ack_i || w_timeout) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Ack has priority over the timeout on the same edge, so a late ack is never flagged.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_adr <= addr;
                        r_dat <= wdata;
                        r_sel <= sel;
                        r_we  <= write_req;
                        r_cnt <= '0;
                        r_err <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (wb_ack_i) begin
                        if (!r_we) r_rdata <= wb_dat_i;
                        r_we  <= 1'b0;
                        r_cnt <= '0;
                        r_err <= 1'b0;
                    end else if (w_timeout) begin
                        if (!r_we) r_rdata <= ERR_DATA;
                        r_we  <= 1'b0;
                        r_cnt <= '0;
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                S_FIN: begin
                    r_err <= 1'b0;
                end
                default: begin
                    r_err <= 1'b0;
                end
            endcase
        end
    end

    // Strobes decode straight from the state so an async reset drops them at once.
    assign wb_cyc_o = (r_state == S_REQ);
    assign wb_stb_o = (r_state == S_REQ);
    assign busy     = (r_state == S_REQ);
    assign done     = (r_state == S_FIN);
    assign err      = (r_state == S_FIN) && r_err;
    assign wb_we_o  = r_we;
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_dat;
    assign wb_sel_o = r_sel;
    assign rdata    = r_rdata;

endmodule

// File: tb/tb_t08_wb_requester.sv
// Directed plus randomized bench for t08_wb_requester against a transaction-level model.
module tb_t08_wb_requester;

    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hBAD0_0BAD;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        read_req = 1'b0;
    logic        write_req = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  sel = '0;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;

    int          checks = 0;
    int          failures = 0;
    int          cyc_n = 0;
    int          done_cnt = 0;
    logic [31:0] exp_rdata = '0;

    t08_wb_requester #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .nrst(nrst),
        .read_req(read_req), .write_req(write_req),
        .addr(addr), .wdata(wdata), .sel(sel),
        .rdata(rdata), .busy(busy), .done(done), .err(err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;
    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transfer; ack_after = stb cycle in which the slave acks (0 = never).
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           input int ack_after, input logic [31:0] rdat);
        logic exp_err;
        int   exp_cyc;
        exp_err = (ack_after == 0) || (ack_after > TO);
        exp_cyc = exp_err ? TO : ack_after;
        @(negedge clk);
        read_req = rd; write_req = wr; addr = a; wdata = d; sel = s;
        @(posedge clk); #1;
        read_req = 1'b0; write_req = 1'b0;
        addr = $urandom; wdata = $urandom; sel = 4'($urandom);
        for (int k = 1; k <= exp_cyc; k++) begin
            @(negedge clk);
            chk("req_cyc", 32'(wb_cyc_o), 32'd1);
            chk("req_stb", 32'(wb_stb_o), 32'd1);
            chk("req_busy", 32'(busy), 32'd1);
            chk("req_done", 32'(done), 32'd0);
            chk("req_we", 32'(wb_we_o), 32'(wr));
            chk("req_adr", wb_adr_o, a);
            chk("req_dat", wb_dat_o, d);
            chk("req_sel", 32'(wb_sel_o), 32'(s));
            wb_ack_i = (k == ack_after);
            wb_dat_i = (k == ack_after) ? rdat : $urandom;
            @(posedge clk); #1;
            wb_ack_i = 1'b0;
        end
        if (rd && !wr) exp_rdata = exp_err ? ERR : rdat;
        @(negedge clk);
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_err", 32'(err), 32'(exp_err));
        chk("fin_busy", 32'(busy), 32'd0);
        chk("fin_cyc", 32'(wb_cyc_o), 32'd0);
        chk("fin_stb", 32'(wb_stb_o), 32'd0);
        chk("fin_we", 32'(wb_we_o), 32'd0);
        chk("fin_rdata", rdata, exp_rdata);
        @(negedge clk);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_err", 32'(err), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_rdata", rdata, exp_rdata);
    endtask

    initial begin
        logic [31:0] bb_dat [3];
        int          last_done;
        int          dc0;
        int          op;

        // Reset state
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_we", 32'(wb_we_o), 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_sel", 32'(wb_sel_o), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(negedge clk); nrst = 1'b1;

        // Write, zero-wait ack: rdata stays 0
        run_txn(1'b0, 1'b1, 32'h0000_000C, 32'h7FFF_FFFF, 4'hF, 1, 32'h1234_5678);
        // Read with 3 wait cycles
        run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 3, 32'hDEAD_BEEF);
        // Timeout read, then normal read
        run_txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h3, 0, 32'h0);
        run_txn(1'b1, 1'b0, 32'h0000_0024, 32'h0, 4'hF, 2, 32'hCAFE_F00D);
        // Timeout write leaves rdata alone
        run_txn(1'b0, 1'b1, 32'h0000_0028, 32'h5555_AAAA, 4'hC, 0, 32'h0);
        // Ack on the final allowed cycle wins over the timeout
        run_txn(1'b1, 1'b0, 32'h0000_0030, 32'h0, 4'hF, TO, 32'h0BAD_F00D);
        // Simultaneous read+write -> write
        run_txn(1'b1, 1'b1, 32'h0000_0040, 32'hA5A5_5A5A, 4'h6, 2, 32'hFFFF_0000);

        // Reset mid-transaction, asserted between clock edges
        @(negedge clk);
        read_req = 1'b1; addr = 32'h0000_0050;
        @(posedge clk); #1; read_req = 1'b0;
        @(posedge clk); #3;
        nrst = 1'b0;
        #1;
        chk("arst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("arst_stb", 32'(wb_stb_o), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        exp_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("arst_hold_done", 32'(done), 32'd0);
            chk("arst_rdata", rdata, exp_rdata);
        end
        nrst = 1'b1;
        run_txn(1'b1, 1'b0, 32'h0000_0054, 32'h0, 4'hF, 2, 32'h0101_0202);

        // Back-to-back reads with read_req held high
        for (int t = 0; t < 3; t++) bb_dat[t] = $urandom;
        dc0 = done_cnt;
        last_done = 0;
        @(negedge clk);
        read_req = 1'b1; addr = 32'h0000_0060;
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("b2b_busy", 32'(busy), 32'd1);
            wb_ack_i = 1'b1; wb_dat_i = bb_dat[t];
            @(posedge clk); #1;
            wb_ack_i = 1'b0;
            @(negedge clk);
            chk("b2b_done", 32'(done), 32'd1);
            chk("b2b_rdata", rdata, bb_dat[t]);
            if (t > 0) chk("b2b_period", 32'(cyc_n - last_done), 32'd3);
            last_done = cyc_n;
            if (t == 2) read_req = 1'b0;
            @(negedge clk);
            chk("b2b_gap_busy", 32'(busy), 32'd0);
            chk("b2b_gap_done", 32'(done), 32'd0);
        end
        exp_rdata = bb_dat[2];
        repeat (3) @(negedge clk);
        chk("b2b_done_count", 32'(done_cnt - dc0), 32'd3);

        // Randomized transfers
        for (int n = 0; n < 24; n++) begin
            op = $urandom_range(0, 2);
            run_txn(op != 1, op != 0, $urandom, $urandom, 4'($urandom),
                    $urandom_range(0, TO + 2), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
